// File: rtl/dmem_loader_pkg.sv
// dmem_loader_pkg: shared widths and loader state encodings
package dmem_loader_pkg;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 16;
  localparam logic [1:0] LD_IDLE   = 2'd0;
  localparam logic [1:0] LD_RECV   = 2'd1;
  localparam logic [1:0] LD_WRITE  = 2'd2;
  localparam logic [1:0] LD_FINISH = 2'd3;
  typedef enum logic [1:0] {
    IDLE   = LD_IDLE,
    RECV   = LD_RECV,
    WRITE  = LD_WRITE,
    FINISH = LD_FINISH
  } loader_state_t;
endpackage

// File: rtl/dmem_loader_if.sv
// dmem_loader_if: byte-stream handshake plus dmem write port
interface dmem_loader_if #(
  parameter int DATA_W = dmem_loader_pkg::DMEM_DATA_W,
  parameter int ADDR_W = dmem_loader_pkg::DMEM_ADDR_W
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  modport master (
    input  byte_valid, byte_data,
    output byte_ready, mem_a, mem_wd, mem_we
  );
  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, mem_a, mem_wd, mem_we
  );
endinterface

// File: rtl/dmem_loader_byte_packer.sv
// dmem_loader_byte_packer: big-endian byte-to-word shift register
module dmem_loader_byte_packer #(
  parameter int DATA_W = dmem_loader_pkg::DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word_out,
  output logic              full
);
  localparam int BYTES_PER_WORD = DATA_W / 8;
  localparam int SW = DATA_W - 8;
  localparam int CW = $clog2(BYTES_PER_WORD + 1);
  logic [SW-1:0] sr;
  logic [CW-1:0] cnt;
  // full flags that the byte on byte_in completes the word shown on word_out
  assign full = cnt == CW'(BYTES_PER_WORD - 1);
  assign word_out = {sr, byte_in};
  // shift earlier bytes toward the MSB lane, wrap the counter on completion
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= SW'({sr, byte_in});
      cnt <= full ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/dmem_loader.sv
// dmem_loader: loads a packed byte stream into dmem while holding the CPU off
module dmem_loader
  import dmem_loader_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              abort,
  dmem_loader_if.master     bus,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done
);
  loader_state_t     state;
  logic [ADDR_W-1:0] base, count, idx;
  logic [DATA_W-1:0] word;
  logic              clr, shift_en, full;
  assign shift_en = state == RECV && bus.byte_ready && bus.byte_valid && !abort;
  assign clr = state == IDLE || abort;
  assign cpu_hold = busy;
  dmem_loader_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .shift_en(shift_en),
    .byte_in(bus.byte_data),
    .word_out(word),
    .full(full)
  );
  // load sequencer; every output is registered so WRITE presents a stable a/wd/we
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      base           <= '0;
      count          <= '0;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.byte_ready <= 1'b0;
      bus.mem_a      <= '0;
      bus.mem_wd     <= '0;
      bus.mem_we     <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: if (start && !abort) begin
          base           <= base_addr;
          count          <= word_count;
          idx            <= '0;
          busy           <= 1'b1;
          state          <= word_count == '0 ? FINISH : RECV;
          done           <= word_count == '0;
          bus.byte_ready <= word_count != '0;
        end
        RECV: if (abort) begin
          state          <= IDLE;
          busy           <= 1'b0;
          bus.byte_ready <= 1'b0;
        end else if (shift_en && full) begin
          state          <= WRITE;
          bus.byte_ready <= 1'b0;
          bus.mem_we     <= 1'b1;
          bus.mem_a      <= base + idx;
          bus.mem_wd     <= word;
        end
        WRITE: begin
          idx <= idx + ADDR_W'(1);
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (idx + ADDR_W'(1) == count) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            state          <= RECV;
            bus.byte_ready <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
